// File: rtl/pipeline_fork_buffered.sv
// rtl/pipeline_fork_buffered.sv - valid/ready fork to N masked consumers with per-channel FIFOs (optional PIPELINE_FORK_BYPASS_EN)
module pipeline_fork_buffered #(
  parameter int N     = 2,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [DW-1:0]          i_data,
  input  logic [N-1:0]           i_mask,
  output logic [N-1:0]           o_valid,
  input  logic [N-1:0]           o_ready,
  output logic [N-1:0][DW-1:0]   o_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q    [N][DEPTH];
  logic [DW-1:0] mem_d    [N][DEPTH];
  logic [PW-1:0] wr_ptr_q [N];
  logic [PW-1:0] wr_ptr_d [N];
  logic [PW-1:0] rd_ptr_q [N];
  logic [PW-1:0] rd_ptr_d [N];
  logic [CW-1:0] cnt_q    [N];
  logic [CW-1:0] cnt_d    [N];

  logic [N-1:0] full;
  logic [N-1:0] empty;
  logic [N-1:0] push;
  logic [N-1:0] pop;
  logic [N-1:0] bypass;
  logic         accept;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake: i_ready looks only at registered fill state and the mask, never o_ready
  always_comb begin
    full    = '0;
    empty   = '0;
    push    = '0;
    pop     = '0;
    bypass  = '0;
    o_valid = '0;
    o_data  = '0;
    for (int i = 0; i < N; i++) begin
      full[i]  = (cnt_q[i] == CW'(DEPTH));
      empty[i] = (cnt_q[i] == '0);
    end
    i_ready = &(~i_mask | ~full);
    accept  = i_valid && i_ready;
    for (int i = 0; i < N; i++) begin
`ifdef PIPELINE_FORK_BYPASS_EN
      // An empty channel presents the incoming beat directly; if taken now it never enters storage
      bypass[i]  = empty[i] && accept && i_mask[i] && o_ready[i];
      o_valid[i] = empty[i] ? (accept && i_mask[i]) : 1'b1;
      o_data[i]  = (empty[i] && accept && i_mask[i]) ? i_data : mem_q[i][rd_ptr_q[i]];
`else
      bypass[i]  = 1'b0;
      o_valid[i] = !empty[i];
      o_data[i]  = mem_q[i][rd_ptr_q[i]];
`endif
      push[i] = accept && i_mask[i] && !bypass[i];
      pop[i]  = !empty[i] && o_ready[i];
    end
  end

  // Next state: write at wr_ptr on push, advance rd_ptr on pop, count tracks the difference
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = i_data;
        wr_ptr_d[i]           = ptr_inc(wr_ptr_q[i]);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      end
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // State registers; reset clears storage so heads read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_chk
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q[g] <= CW'(DEPTH));
    a_no_over:   assert property (@(posedge clk) disable iff (!rst_n) !(full[g] && push[g]));
    a_no_under:  assert property (@(posedge clk) disable iff (!rst_n) !(empty[g] && pop[g]));
  end

endmodule

// File: tb/tb_pipeline_fork_buffered.sv
// tb/tb_pipeline_fork_buffered.sv - self-checking bench for pipeline_fork_buffered
module tb_pipeline_fork_buffered;

  logic              clk;
  logic              rst_n;
  logic              a_valid, a_ready;
  logic [31:0]       a_data;
  logic [1:0]        a_mask, a_ovalid, a_oready;
  logic [1:0][31:0]  a_odata;
  logic              b_valid, b_ready;
  logic [31:0]       b_data;
  logic [1:0]        b_mask, b_ovalid, b_oready;
  logic [1:0][31:0]  b_odata;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] sq0[$];
  logic [31:0] sq1[$];

  pipeline_fork_buffered #(.N(2), .DW(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .i_ready(a_ready), .i_data(a_data),
    .i_mask(a_mask), .o_valid(a_ovalid), .o_ready(a_oready), .o_data(a_odata));

  pipeline_fork_buffered #(.N(2), .DW(32), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_valid(b_valid), .i_ready(b_ready), .i_data(b_data),
    .i_mask(b_mask), .o_valid(b_ovalid), .o_ready(b_oready), .o_data(b_odata));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  m;
    logic [31:0] d;
    logic [1:0]  r;
    logic        er;
    logic [1:0]  ev;
    logic [31:0] ed0;
    logic [31:0] ed1;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int sent;
    logic exp_rdy;
    a_valid = 0; a_data = 0; a_mask = 0; a_oready = 0;
    b_valid = 0; b_data = 0; b_mask = 0; b_oready = 0;
    rst_n = 0;

    tbl[0]  = '{1'b1, 2'b11, 32'hA5, 2'b11, 1'b1, 2'b00, 32'h0,  32'h0};
    tbl[1]  = '{1'b0, 2'b00, 32'h0,  2'b11, 1'b1, 2'b11, 32'hA5, 32'hA5};
    tbl[2]  = '{1'b0, 2'b00, 32'h0,  2'b11, 1'b1, 2'b00, 32'h0,  32'h0};
    tbl[3]  = '{1'b1, 2'b11, 32'h1,  2'b01, 1'b1, 2'b00, 32'h0,  32'h0};
    tbl[4]  = '{1'b1, 2'b11, 32'h2,  2'b01, 1'b1, 2'b11, 32'h1,  32'h1};
    tbl[5]  = '{1'b1, 2'b11, 32'h3,  2'b01, 1'b0, 2'b11, 32'h2,  32'h1};
    tbl[6]  = '{1'b1, 2'b11, 32'h3,  2'b01, 1'b0, 2'b10, 32'h0,  32'h1};
    tbl[7]  = '{1'b1, 2'b01, 32'h4,  2'b00, 1'b1, 2'b10, 32'h0,  32'h1};
    tbl[8]  = '{1'b1, 2'b00, 32'h5,  2'b00, 1'b1, 2'b11, 32'h4,  32'h1};
    tbl[9]  = '{1'b0, 2'b00, 32'h0,  2'b00, 1'b1, 2'b11, 32'h4,  32'h1};
    tbl[10] = '{1'b1, 2'b11, 32'h6,  2'b11, 1'b0, 2'b11, 32'h4,  32'h1};
    tbl[11] = '{1'b0, 2'b00, 32'h0,  2'b11, 1'b1, 2'b10, 32'h0,  32'h2};
    tbl[12] = '{1'b0, 2'b00, 32'h0,  2'b00, 1'b1, 2'b00, 32'h0,  32'h0};

    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #2;
    chk("rst_ovalid", a_ovalid, 2'b00);
    chk("rst_odata0", a_odata[0], 32'h0);
    chk("rst_odata1", a_odata[1], 32'h0);
    chk("rst_iready", a_ready, 1'b1);

`ifndef PIPELINE_FORK_BYPASS_EN
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      a_valid = tbl[k].v; a_mask = tbl[k].m; a_data = tbl[k].d; a_oready = tbl[k].r;
      #2;
      chk($sformatf("vec%0d_iready", k), a_ready, tbl[k].er);
      chk($sformatf("vec%0d_ovalid", k), a_ovalid, tbl[k].ev);
      if (tbl[k].ev[0]) chk($sformatf("vec%0d_odata0", k), a_odata[0], tbl[k].ed0);
      if (tbl[k].ev[1]) chk($sformatf("vec%0d_odata1", k), a_odata[1], tbl[k].ed1);
    end
`else
    @(posedge clk); #1;
    a_valid = 1; a_mask = 2'b11; a_data = 32'h5A; a_oready = 2'b11;
    #2;
    chk("byp_ovalid", a_ovalid, 2'b11);
    chk("byp_odata0", a_odata[0], 32'h5A);
    chk("byp_odata1", a_odata[1], 32'h5A);
    chk("byp_iready", a_ready, 1'b1);
    @(posedge clk); #1;
    a_valid = 0; a_mask = 2'b00;
    #2;
    chk("byp_nocnt_ovalid", a_ovalid, 2'b00);
    @(posedge clk); #1;
    a_valid = 1; a_mask = 2'b01; a_data = 32'h77; a_oready = 2'b00;
    #2;
    chk("byp_stall_ovalid", a_ovalid, 2'b01);
    chk("byp_stall_odata0", a_odata[0], 32'h77);
    @(posedge clk); #1;
    a_valid = 0; a_mask = 2'b00;
    #2;
    chk("byp_held_ovalid", a_ovalid, 2'b01);
    chk("byp_held_odata0", a_odata[0], 32'h77);
    @(posedge clk); #1;
    a_oready = 2'b11;
    @(posedge clk); #1;
    a_oready = 2'b00;
`endif

    // reset with one entry held in each channel
    @(posedge clk); #1;
    a_valid = 1; a_mask = 2'b11; a_data = 32'h11; a_oready = 2'b00;
    @(posedge clk); #1;
    a_valid = 0; a_mask = 2'b00;
    #1;
    chk("pre_rst_ovalid", a_ovalid, 2'b11);
    rst_n = 0;
    #1;
    chk("mid_rst_ovalid", a_ovalid, 2'b00);
    chk("mid_rst_odata0", a_odata[0], 32'h0);
    @(posedge clk); #1;
    rst_n = 1; a_mask = 2'b11;
    #2;
    chk("post_rst_iready", a_ready, 1'b1);
    chk("post_rst_ovalid", a_ovalid, 2'b00);
    a_mask = 2'b00;

    // random masked traffic on the depth-3 instance against a scoreboard
    sent = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (sent == 10 && sq0.size() == 0 && sq1.size() == 0) break;
      @(posedge clk); #1;
      b_valid  = (sent < 10);
      b_mask   = 2'($urandom_range(0, 3));
      b_data   = $urandom;
      b_oready = 2'($urandom_range(0, 3));
      #2;
      exp_rdy = (!b_mask[0] || sq0.size() < 3) && (!b_mask[1] || sq1.size() < 3);
      chk("t5_iready", b_ready, exp_rdy);
`ifndef PIPELINE_FORK_BYPASS_EN
      chk("t5_ovalid0", b_ovalid[0], sq0.size() != 0);
      chk("t5_ovalid1", b_ovalid[1], sq1.size() != 0);
`endif
      if (b_valid && b_ready) begin
        if (b_mask[0]) sq0.push_back(b_data);
        if (b_mask[1]) sq1.push_back(b_data);
        sent++;
      end
      if (b_ovalid[0] && b_oready[0]) begin
        chk("t5_ch0_has_exp", sq0.size() != 0, 1'b1);
        if (sq0.size() != 0) chk("t5_ch0_data", b_odata[0], sq0.pop_front());
      end
      if (b_ovalid[1] && b_oready[1]) begin
        chk("t5_ch1_has_exp", sq1.size() != 0, 1'b1);
        if (sq1.size() != 0) chk("t5_ch1_data", b_odata[1], sq1.pop_front());
      end
    end
    b_valid = 0; b_oready = 0;
    chk("t5_sent", sent, 10);
    chk("t5_left0", sq0.size(), 0);
    chk("t5_left1", sq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
